// File: rtl/wishbone_arbiter_if.sv
// ---------------------------------------------------------------------------
// wishbone_arbiter_if
//
// Bundles every bus signal of the round-robin Wishbone arbiter: the
// NUM_CTRL controller-side ports, the one-hot grant and the single
// device-side port. Signal names keep their _i/_o suffixes as seen from
// the arbiter, so they read the same on both sides of the connection.
//
// Modports:
//   slave  - the arbiter itself (takes c_*_i / d_*_i, drives c_*_o / d_*_o)
//   master - the surrounding system or bench (opposite directions)
//
// Signals:
//   c_cyc_i, c_stb_i, c_we_i  [NUM_CTRL]            per-controller cycle/strobe/write
//   c_dat_i                   [NUM_CTRL*DAT_WIDTH]  controller k at [k*DAT_WIDTH +: DAT_WIDTH]
//   c_ack_o, c_err_o, c_rty_o [NUM_CTRL]            per-controller responses
//   c_stall_o                 [NUM_CTRL]            per-controller stall
//   gnt_o                     [NUM_CTRL]            registered one-hot grant
//   d_cyc_o, d_stb_o, d_we_o, d_dat_o               device request
//   d_ack_i, d_err_i, d_rty_i, d_stall_i            device response
// ---------------------------------------------------------------------------
interface wishbone_arbiter_if #(
    parameter int DAT_WIDTH = 8,
    parameter int NUM_CTRL  = 4
);
    logic [NUM_CTRL-1:0]           c_cyc_i;
    logic [NUM_CTRL-1:0]           c_stb_i;
    logic [NUM_CTRL-1:0]           c_we_i;
    logic [NUM_CTRL*DAT_WIDTH-1:0] c_dat_i;
    logic [NUM_CTRL-1:0]           c_ack_o;
    logic [NUM_CTRL-1:0]           c_err_o;
    logic [NUM_CTRL-1:0]           c_rty_o;
    logic [NUM_CTRL-1:0]           c_stall_o;
    logic [NUM_CTRL-1:0]           gnt_o;

    logic                          d_cyc_o;
    logic                          d_stb_o;
    logic                          d_we_o;
    logic [DAT_WIDTH-1:0]          d_dat_o;
    logic                          d_ack_i;
    logic                          d_err_i;
    logic                          d_rty_i;
    logic                          d_stall_i;

    modport slave (
        input  c_cyc_i, c_stb_i, c_we_i, c_dat_i,
        output c_ack_o, c_err_o, c_rty_o, c_stall_o, gnt_o,
        output d_cyc_o, d_stb_o, d_we_o, d_dat_o,
        input  d_ack_i, d_err_i, d_rty_i, d_stall_i
    );

    modport master (
        output c_cyc_i, c_stb_i, c_we_i, c_dat_i,
        input  c_ack_o, c_err_o, c_rty_o, c_stall_o, gnt_o,
        input  d_cyc_o, d_stb_o, d_we_o, d_dat_o,
        output d_ack_i, d_err_i, d_rty_i, d_stall_i
    );
endinterface

// File: rtl/wishbone_arbiter.sv
// ---------------------------------------------------------------------------
// wishbone_arbiter
//
// Shares one Wishbone device port among NUM_CTRL controllers with
// round-robin arbitration. A grant is taken in IDLE, held for the whole
// bus cycle (while the granted controller keeps cyc high) and never
// pre-empted. The device request is a combinational mux of the granted
// controller; device responses go back to that controller only, every
// other controller sees no response and a permanent stall.
//
// Ports:
//   clk_i   - clock
//   rst_ni  - asynchronous active-low reset
//   bus     - wishbone_arbiter_if.slave (controller ports, grant, device port)
//
// Parameters:
//   DAT_WIDTH      - data bus width
//   NUM_CTRL       - number of controllers (2..16)
//   TIMEOUT_CYCLES - watchdog limit, only used with WB_ARB_TIMEOUT_EN
//
// Build option:
//   WB_ARB_TIMEOUT_EN - adds a watchdog: a granted cycle with no device
//   response for TIMEOUT_CYCLES cycles gets a one-cycle c_err_o pulse and
//   is parked in ABORT until the controller drops cyc.
// ---------------------------------------------------------------------------
module wishbone_arbiter #(
    parameter int DAT_WIDTH      = 8,
    parameter int NUM_CTRL       = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic              clk_i,
    input logic              rst_ni,
    wishbone_arbiter_if.slave bus
);

    localparam int IDX_W = (NUM_CTRL > 1) ? $clog2(NUM_CTRL) : 1;

    // Elaboration-time guard against unsupported configurations.
    if (NUM_CTRL < 2 || NUM_CTRL > 16 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("wishbone_arbiter: NUM_CTRL must be 2..16 and TIMEOUT_CYCLES >= 2");
    end

`ifdef WB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
`else
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;
`endif

    state_t              state;
    logic [IDX_W-1:0]    ptr;       // last winner; equals the granted index while BUSY
    logic [NUM_CTRL-1:0] gnt;

    // Per-controller write data unpacked so the mux is a plain array index.
    logic [DAT_WIDTH-1:0] c_dat [NUM_CTRL];

    for (genvar k = 0; k < NUM_CTRL; k++) begin : g_unpack
        assign c_dat[k] = bus.c_dat_i[k*DAT_WIDTH +: DAT_WIDTH];
    end

    // Request of the currently granted controller.
    logic                 sel_cyc;
    logic                 sel_stb;
    logic                 sel_we;
    logic [DAT_WIDTH-1:0] sel_dat;

    assign sel_cyc = bus.c_cyc_i[ptr];
    assign sel_stb = bus.c_stb_i[ptr];
    assign sel_we  = bus.c_we_i[ptr];
    assign sel_dat = c_dat[ptr];

    // ------------------------------------------------------------------
    // Round-robin pick: first requesting controller searching upward from
    // ptr+1, wrapping at NUM_CTRL. Looping i = 1..NUM_CTRL visits ptr last,
    // which is what gives every other requester priority over the previous
    // winner.
    // ------------------------------------------------------------------
    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] cand;

    // NOTE: every signal written in always_comb gets a default up front so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr;
        cand      = '0;
        for (int i = 1; i <= NUM_CTRL; i++) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_CTRL);
            if (!win_found && bus.c_cyc_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;
    logic             timeout_hit;
    logic             any_rsp;

    assign any_rsp     = bus.d_ack_i | bus.d_err_i | bus.d_rty_i;
    assign timeout_hit = (state == BUSY) && sel_cyc &&
                         (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    // ------------------------------------------------------------------
    // Control FSM: state, grant pointer, registered one-hot grant and, in
    // the watchdog build, the no-response counter.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            ptr   <= IDX_W'(NUM_CTRL - 1);   // controller 0 wins first
            gnt   <= '0;
`ifdef WB_ARB_TIMEOUT_EN
            cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state <= BUSY;
                        ptr   <= win_idx;
                        gnt   <= NUM_CTRL'(1) << win_idx;
`ifdef WB_ARB_TIMEOUT_EN
                        cnt   <= '0;
`endif
                    end
                end

                BUSY: begin
                    if (!sel_cyc) begin
                        // Release; re-arbitration happens in the IDLE cycle.
                        state <= IDLE;
                        gnt   <= '0;
`ifdef WB_ARB_TIMEOUT_EN
                    end else if (timeout_hit) begin
                        state <= ABORT;
                    end else if (any_rsp) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
`endif
                    end
                end

`ifdef WB_ARB_TIMEOUT_EN
                ABORT: begin
                    // Grant stays parked until the controller gives up.
                    if (!sel_cyc) begin
                        state <= IDLE;
                        gnt   <= '0;
                    end
                end
`endif

                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

    assign bus.gnt_o = gnt;

    // ------------------------------------------------------------------
    // Combinational request mux and response routing. Only BUSY connects
    // a controller to the device; IDLE (and ABORT) leave the device idle,
    // drop device responses and stall every controller.
    // ------------------------------------------------------------------
    always_comb begin
        bus.d_cyc_o   = 1'b0;
        bus.d_stb_o   = 1'b0;
        bus.d_we_o    = 1'b0;
        bus.d_dat_o   = '0;
        bus.c_ack_o   = '0;
        bus.c_err_o   = '0;
        bus.c_rty_o   = '0;
        bus.c_stall_o = '1;

        if (state == BUSY) begin
            bus.d_cyc_o        = sel_cyc;
            bus.d_stb_o        = sel_stb;
            bus.d_we_o         = sel_we;
            bus.d_dat_o        = sel_dat;
            bus.c_ack_o[ptr]   = bus.d_ack_i;
            bus.c_err_o[ptr]   = bus.d_err_i;
            bus.c_rty_o[ptr]   = bus.d_rty_i;
            bus.c_stall_o[ptr] = bus.d_stall_i;
`ifdef WB_ARB_TIMEOUT_EN
            // Watchdog error replaces whatever the device reports this cycle.
            if (timeout_hit) begin
                bus.c_err_o[ptr] = 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wishbone_arbiter
//
// Directed bench for wishbone_arbiter (NUM_CTRL=4, DAT_WIDTH=8). A table of
// per-cycle input/expected-output records walks through arbitration,
// routing and release; hand-written sequences cover device stall,
// asynchronous reset mid-cycle and the watchdog (or its absence).
// Inputs change 2 time units after the rising edge and outputs are
// compared 1 unit later, well away from either clock edge.
// ---------------------------------------------------------------------------
module tb_wishbone_arbiter;

    localparam int DW = 8;
    localparam int NC = 4;
`ifdef WB_ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 256;
`endif

    logic clk;
    logic rst_n;

    wishbone_arbiter_if #(.DAT_WIDTH(DW), .NUM_CTRL(NC)) bus ();

    wishbone_arbiter #(
        .DAT_WIDTH      (DW),
        .NUM_CTRL       (NC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [3:0] cyc, input logic [3:0] stb, input logic [3:0] we,
                         input logic ack, input logic err, input logic rty, input logic stall);
        bus.c_cyc_i   = cyc;
        bus.c_stb_i   = stb;
        bus.c_we_i    = we;
        bus.d_ack_i   = ack;
        bus.d_err_i   = err;
        bus.d_rty_i   = rty;
        bus.d_stall_i = stall;
    endtask

    typedef struct {
        logic [3:0]  cyc, stb, we;
        logic        ack, err, rty, stall;
        logic [3:0]  e_gnt;
        logic        e_cyc, e_stb, e_we;
        logic [7:0]  e_dat;
        logic [3:0]  e_ack, e_err, e_rty, e_stall;
    } vec_t;

    localparam logic [31:0] DATA = 32'h3322_11A5;  // c3=33 c2=22 c1=11 c0=A5

    vec_t vec [17];

    initial begin
        //            cyc      stb      we       ack   err   rty   stl     gnt      dc    ds    dw    dat     ack      err      rty      stall
        vec[0]  = '{4'b0001,4'b0001,4'b0001,1'b0,1'b0,1'b0,1'b0,  4'b0000,1'b0,1'b0,1'b0,8'h00,  4'b0000,4'b0000,4'b0000,4'b1111};
        vec[1]  = '{4'b0001,4'b0001,4'b0001,1'b1,1'b0,1'b0,1'b0,  4'b0001,1'b1,1'b1,1'b1,8'hA5,  4'b0001,4'b0000,4'b0000,4'b1110};
        vec[2]  = '{4'b0000,4'b0000,4'b0000,1'b0,1'b0,1'b0,1'b0,  4'b0001,1'b0,1'b0,1'b0,8'hA5,  4'b0000,4'b0000,4'b0000,4'b1110};
        vec[3]  = '{4'b1111,4'b1111,4'b0000,1'b0,1'b0,1'b0,1'b0,  4'b0000,1'b0,1'b0,1'b0,8'h00,  4'b0000,4'b0000,4'b0000,4'b1111};
        vec[4]  = '{4'b1111,4'b1111,4'b0000,1'b1,1'b0,1'b0,1'b0,  4'b0010,1'b1,1'b1,1'b0,8'h11,  4'b0010,4'b0000,4'b0000,4'b1101};
        vec[5]  = '{4'b1101,4'b1101,4'b0000,1'b0,1'b0,1'b0,1'b0,  4'b0010,1'b0,1'b0,1'b0,8'h11,  4'b0000,4'b0000,4'b0000,4'b1101};
        vec[6]  = '{4'b1101,4'b1101,4'b0000,1'b0,1'b0,1'b0,1'b0,  4'b0000,1'b0,1'b0,1'b0,8'h00,  4'b0000,4'b0000,4'b0000,4'b1111};
        vec[7]  = '{4'b1111,4'b1111,4'b0010,1'b0,1'b1,1'b0,1'b1,  4'b0100,1'b1,1'b1,1'b0,8'h22,  4'b0000,4'b0100,4'b0000,4'b1111};
        vec[8]  = '{4'b1111,4'b1111,4'b0010,1'b0,1'b0,1'b1,1'b0,  4'b0100,1'b1,1'b1,1'b0,8'h22,  4'b0000,4'b0000,4'b0100,4'b1011};
        vec[9]  = '{4'b1011,4'b1011,4'b0010,1'b0,1'b0,1'b0,1'b0,  4'b0100,1'b0,1'b0,1'b0,8'h22,  4'b0000,4'b0000,4'b0000,4'b1011};
        vec[10] = '{4'b1011,4'b1011,4'b0000,1'b0,1'b0,1'b0,1'b0,  4'b0000,1'b0,1'b0,1'b0,8'h00,  4'b0000,4'b0000,4'b0000,4'b1111};
        vec[11] = '{4'b1011,4'b1011,4'b0000,1'b1,1'b0,1'b0,1'b0,  4'b1000,1'b1,1'b1,1'b0,8'h33,  4'b1000,4'b0000,4'b0000,4'b0111};
        vec[12] = '{4'b0011,4'b0011,4'b0000,1'b0,1'b0,1'b0,1'b0,  4'b1000,1'b0,1'b0,1'b0,8'h33,  4'b0000,4'b0000,4'b0000,4'b0111};
        vec[13] = '{4'b0011,4'b0010,4'b0000,1'b0,1'b0,1'b0,1'b0,  4'b0000,1'b0,1'b0,1'b0,8'h00,  4'b0000,4'b0000,4'b0000,4'b1111};
        vec[14] = '{4'b0011,4'b0010,4'b0010,1'b0,1'b0,1'b0,1'b0,  4'b0001,1'b1,1'b0,1'b0,8'hA5,  4'b0000,4'b0000,4'b0000,4'b1110};
        vec[15] = '{4'b0000,4'b0000,4'b0000,1'b0,1'b0,1'b0,1'b0,  4'b0001,1'b0,1'b0,1'b0,8'hA5,  4'b0000,4'b0000,4'b0000,4'b1110};
        vec[16] = '{4'b0000,4'b0000,4'b0000,1'b1,1'b1,1'b1,1'b0,  4'b0000,1'b0,1'b0,1'b0,8'h00,  4'b0000,4'b0000,4'b0000,4'b1111};

        // ---------------- reset ----------------
        rst_n       = 1'b0;
        bus.c_dat_i = DATA;
        drive(4'b1111, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);  // requests during reset
        tick();
        tick();
        check("rst gnt",   32'(bus.gnt_o),     32'h0);
        check("rst d_cyc", 32'(bus.d_cyc_o),   32'h0);
        check("rst d_stb", 32'(bus.d_stb_o),   32'h0);
        check("rst d_dat", 32'(bus.d_dat_o),   32'h0);
        check("rst ack",   32'(bus.c_ack_o),   32'h0);
        check("rst stall", 32'(bus.c_stall_o), 32'hF);
        drive(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 17; i++) begin
            drive(vec[i].cyc, vec[i].stb, vec[i].we, vec[i].ack, vec[i].err, vec[i].rty, vec[i].stall);
            #1;
            check($sformatf("v%0d gnt", i),   32'(bus.gnt_o),     32'(vec[i].e_gnt));
            check($sformatf("v%0d d_cyc", i), 32'(bus.d_cyc_o),   32'(vec[i].e_cyc));
            check($sformatf("v%0d d_stb", i), 32'(bus.d_stb_o),   32'(vec[i].e_stb));
            check($sformatf("v%0d d_we", i),  32'(bus.d_we_o),    32'(vec[i].e_we));
            check($sformatf("v%0d d_dat", i), 32'(bus.d_dat_o),   32'(vec[i].e_dat));
            check($sformatf("v%0d ack", i),   32'(bus.c_ack_o),   32'(vec[i].e_ack));
            check($sformatf("v%0d err", i),   32'(bus.c_err_o),   32'(vec[i].e_err));
            check($sformatf("v%0d rty", i),   32'(bus.c_rty_o),   32'(vec[i].e_rty));
            check($sformatf("v%0d stall", i), 32'(bus.c_stall_o), 32'(vec[i].e_stall));
            tick();
        end

        // ---------------- device stall for 3 cycles (pointer now 0) ----------------
        drive(4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("stl gnt", 32'(bus.gnt_o), 32'h4);
        for (int c = 0; c < 3; c++) begin
            drive(4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
            #1;
            check($sformatf("stl%0d stall", c), 32'(bus.c_stall_o), 32'hF);
            tick();
        end
        drive(4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("stl end stall", 32'(bus.c_stall_o), 32'hB);
        check("stl end ack",   32'(bus.c_ack_o),   32'h4);
        tick();
        drive(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();

        // ---------------- async reset mid-BUSY (pointer now 2 -> ctrl 1 wins) ----------------
        drive(4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("ar pre gnt",   32'(bus.gnt_o),   32'h2);
        check("ar pre d_cyc", 32'(bus.d_cyc_o), 32'h1);
        rst_n = 1'b0;
        #1;
        check("ar d_cyc", 32'(bus.d_cyc_o),   32'h0);
        check("ar gnt",   32'(bus.gnt_o),     32'h0);
        check("ar stall", 32'(bus.c_stall_o), 32'hF);
        drive(4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("ar held gnt", 32'(bus.gnt_o), 32'h0);
        rst_n = 1'b1;
        tick();
        check("ar first gnt", 32'(bus.gnt_o), 32'h1);
        drive(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();

        // ---------------- watchdog (pointer now 0 -> ctrl 1 wins) ----------------
        drive(4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("wd gnt", 32'(bus.gnt_o), 32'h2);
`ifdef WB_ARB_TIMEOUT_EN
        for (int c = 0; c < TO; c++) begin
            #1;
            check($sformatf("wd c%0d err", c),   32'(bus.c_err_o), (c == TO - 1) ? 32'h2 : 32'h0);
            check($sformatf("wd c%0d d_cyc", c), 32'(bus.d_cyc_o), 32'h1);
            tick();
        end
        for (int c = 0; c < 2; c++) begin
            bus.d_ack_i = 1'b1;
            #1;
            check($sformatf("ab%0d d_cyc", c), 32'(bus.d_cyc_o),   32'h0);
            check($sformatf("ab%0d stall", c), 32'(bus.c_stall_o), 32'hF);
            check($sformatf("ab%0d ack", c),   32'(bus.c_ack_o),   32'h0);
            check($sformatf("ab%0d gnt", c),   32'(bus.gnt_o),     32'h2);
            tick();
        end
        drive(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("ab exit gnt", 32'(bus.gnt_o), 32'h0);
`else
        // Without the watchdog a silent device simply keeps the grant.
        for (int c = 0; c < 20; c++) begin
            #1;
            check($sformatf("nwd c%0d err", c), 32'(bus.c_err_o), 32'h0);
            tick();
        end
        #1;
        check("nwd d_cyc", 32'(bus.d_cyc_o), 32'h1);
        check("nwd gnt",   32'(bus.gnt_o),   32'h2);
        drive(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("nwd exit gnt", 32'(bus.gnt_o), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
